// File: rtl/image_ctrl_pkg.sv
// Shared definitions for the image stream sequencer, its source/sink and bench.
package image_ctrl_pkg;

  localparam int unsigned DEF_WIDTH          = 768;
  localparam int unsigned DEF_HEIGHT         = 512;
  localparam int unsigned DEF_START_UP_DELAY = 100;
  localparam int unsigned DEF_HSYNC_DELAY    = 160;
  localparam bit          DEF_BOTTOM_UP      = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_VSYNC,
    ST_DATA,
    ST_HBLANK,
    ST_DONE
  } ctrl_state_t;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/image_delay_cnt.sv
// Loadable down-counter timing the VSYNC and HBLANK phases; done_c flags the last cycle.
module image_delay_cnt #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         done_c
);

  logic [W-1:0] count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (count != '0) begin
      count <= count - W'(1);
    end
  end

  assign done_c = (count == W'(1));

endmodule

// File: rtl/image_stream_ctrl.sv
// Frame sequencer for the two-pixels-per-cycle image stream: VSYNC/HSYNC timing
// and pixel-pair addressing, with start/abort control and downstream stall.
module image_stream_ctrl
  import image_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH          = DEF_WIDTH,
  parameter int unsigned HEIGHT         = DEF_HEIGHT,
  parameter int unsigned START_UP_DELAY = DEF_START_UP_DELAY,
  parameter int unsigned HSYNC_DELAY    = DEF_HSYNC_DELAY,
  parameter bit          BOTTOM_UP      = DEF_BOTTOM_UP,
  localparam int unsigned RW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1,
  localparam int unsigned CW = $clog2(WIDTH),
  localparam int unsigned AW = $clog2(WIDTH * HEIGHT)
) (
  input  logic          HCLK,
  input  logic          HRESET,
  input  logic          start,
  input  logic          abort,
  input  logic          stall,
  output logic          VSYNC,
  output logic          HSYNC,
  output logic [RW-1:0] row,
  output logic [CW-1:0] col,
  output logic [AW-1:0] pix_addr,
  output logic          line_end,
  output logic          busy,
  output logic          frame_done,
  output logic          ctrl_done
);

  localparam int unsigned DW = $clog2(max_u(START_UP_DELAY, HSYNC_DELAY) + 1);
  localparam logic [RW-1:0] FIRST_ROW  = BOTTOM_UP ? RW'(HEIGHT - 1) : '0;
  localparam logic [RW-1:0] LAST_ROW   = BOTTOM_UP ? '0 : RW'(HEIGHT - 1);
  localparam logic [AW-1:0] FIRST_ADDR = BOTTOM_UP ? AW'((HEIGHT - 1) * WIDTH) : '0;
  localparam logic [CW-1:0] LAST_COL   = CW'(WIDTH - 2);

  if (WIDTH < 2 || (WIDTH % 2) != 0) begin : g_bad_width
    $error("image_stream_ctrl: WIDTH must be even and >= 2");
  end
  if (HEIGHT < 1 || START_UP_DELAY < 1 || HSYNC_DELAY < 1) begin : g_bad_timing
    $error("image_stream_ctrl: HEIGHT and both delays must be >= 1");
  end

  ctrl_state_t   state, state_nxt;
  logic          vsync_nxt, hsync_nxt, line_end_nxt, busy_nxt;
  logic          frame_done_nxt, ctrl_done_nxt;
  logic [RW-1:0] row_nxt;
  logic [CW-1:0] col_nxt;
  logic [AW-1:0] addr_nxt;
  logic          cnt_load, cnt_done_c;
  logic [DW-1:0] cnt_val;

  image_delay_cnt #(.W(DW)) u_delay_cnt (
    .clk      (HCLK),
    .rst      (HRESET),
    .load     (cnt_load),
    .load_val (cnt_val),
    .done_c   (cnt_done_c)
  );

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      state      <= ST_IDLE;
      VSYNC      <= 1'b0;
      HSYNC      <= 1'b0;
      row        <= FIRST_ROW;
      col        <= '0;
      pix_addr   <= FIRST_ADDR;
      line_end   <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      ctrl_done  <= 1'b0;
    end else begin
      state      <= state_nxt;
      VSYNC      <= vsync_nxt;
      HSYNC      <= hsync_nxt;
      row        <= row_nxt;
      col        <= col_nxt;
      pix_addr   <= addr_nxt;
      line_end   <= line_end_nxt;
      busy       <= busy_nxt;
      frame_done <= frame_done_nxt;
      ctrl_done  <= ctrl_done_nxt;
    end
  end

  // Registers hold the pair last presented; a pair is presented on the edge entering
  // DATA and on every unstalled DATA edge thereafter, so stall never skips or repeats.
  always_comb begin
    state_nxt      = state;
    hsync_nxt      = 1'b0;
    row_nxt        = row;
    col_nxt        = col;
    addr_nxt       = pix_addr;
    frame_done_nxt = 1'b0;
    ctrl_done_nxt  = ctrl_done;
    cnt_load       = 1'b0;
    cnt_val        = '0;

    if (abort) begin
      state_nxt = ST_IDLE;
      row_nxt   = FIRST_ROW;
      col_nxt   = '0;
      addr_nxt  = FIRST_ADDR;
    end else begin
      unique case (state)
        ST_IDLE, ST_DONE: begin
          if (state == ST_DONE) state_nxt = ST_IDLE;
          if (start) begin
            state_nxt     = ST_VSYNC;
            cnt_load      = 1'b1;
            cnt_val       = DW'(START_UP_DELAY);
            ctrl_done_nxt = 1'b0;
            row_nxt       = FIRST_ROW;
            col_nxt       = '0;
            addr_nxt      = FIRST_ADDR;
          end
        end
        ST_VSYNC, ST_HBLANK: begin
          if (cnt_done_c) begin
            state_nxt = ST_DATA;
            hsync_nxt = 1'b1;
          end
        end
        ST_DATA: begin
          if (!stall) begin
            if (col != LAST_COL) begin
              hsync_nxt = 1'b1;
              col_nxt   = col + CW'(2);
              addr_nxt  = pix_addr + AW'(2);
            end else if (row == LAST_ROW) begin
              state_nxt      = ST_DONE;
              frame_done_nxt = 1'b1;
              ctrl_done_nxt  = 1'b1;
            end else begin
              state_nxt = ST_HBLANK;
              cnt_load  = 1'b1;
              cnt_val   = DW'(HSYNC_DELAY);
              col_nxt   = '0;
              row_nxt   = BOTTOM_UP ? row - RW'(1) : row + RW'(1);
              addr_nxt  = AW'(row_nxt) * AW'(WIDTH);
            end
          end
        end
        default: state_nxt = ST_IDLE;
      endcase
    end

    vsync_nxt    = (state_nxt == ST_VSYNC);
    busy_nxt     = (state_nxt != ST_IDLE);
    line_end_nxt = hsync_nxt && (col_nxt == LAST_COL);
  end

endmodule

// File: doc/image_stream_ctrl.md
Name: image_stream_ctrl

Overview:
Frame sequencer for the two-pixels-per-cycle RGB image stream. It generates VSYNC, HSYNC and pixel-pair addresses (row, column, linear index) for the pixel source, and HSYNC acts as the write strobe for the image sink. It handles start/abort control, startup and inter-line blanking, and downstream stall. It reports frame completion via ctrl_done and a one-cycle frame_done pulse.

Parameters:
WIDTH, 768, pixels per line; even, >=2
HEIGHT, 512, lines per frame; >=1
START_UP_DELAY, 100, VSYNC cycles before the first line; >=1
HSYNC_DELAY, 160, blank cycles between lines; >=1
BOTTOM_UP, 1, 1: row runs HEIGHT-1 down to 0 (BMP order); 0: row runs 0 up to HEIGHT-1

Ports:
HCLK  in  1  clock, rising edge
HRESET  in  1  reset, asynchronous, active-high
start  in  1  single-cycle request; sampled only in IDLE or DONE
abort  in  1  return to IDLE next cycle from any state
stall  in  1  downstream not ready; freezes the data phase
VSYNC  out  1  high during the startup-delay phase
HSYNC  out  1  pixel-pair valid/write strobe
row  out  $clog2(HEIGHT)  current line
col  out  $clog2(WIDTH)  even column of the left pixel of the pair
pix_addr  out  $clog2(WIDTH*HEIGHT)  row*WIDTH+col, aligned with row/col
line_end  out  1  HSYNC && col==WIDTH-2
busy  out  1  state is not IDLE
frame_done  out  1  one-cycle pulse at end of frame
ctrl_done  out  1  sticky; set at end of frame, cleared on accepted start

Behaviour:
- Clock and reset: one clock, HCLK. HRESET is asynchronous and active-high.
- Reset values: state=IDLE; all outputs 0, except row=(BOTTOM_UP?HEIGHT-1:0) and pix_addr=row*WIDTH. Reset asserted mid-frame aborts immediately, with no frame_done.
- All outputs are registered.
- FSM states: IDLE, VSYNC, DATA, HBLANK, DONE.
- IDLE:
  - start=1 -> VSYNC; load delay counter with START_UP_DELAY; clear ctrl_done; set row/col to the first pair.
- VSYNC:
  - VSYNC=1 for exactly START_UP_DELAY cycles, then -> DATA.
  - First HSYNC appears START_UP_DELAY+1 cycles after start is sampled.
- DATA:
  - HSYNC = !stall. Each non-stalled cycle: col+=2 and pix_addr+=2.
  - stall=1 holds row, col and pix_addr with HSYNC=0. Stall has no effect in other states.
  - Non-stalled cycle with col==WIDTH-2, last row -> DONE.
  - Non-stalled cycle with col==WIDTH-2, otherwise -> HBLANK; load HSYNC_DELAY; col=0; row steps ±1; pix_addr=new_row*WIDTH.
- HBLANK:
  - HSYNC=0, VSYNC=0 for HSYNC_DELAY cycles, then -> DATA.
- DONE:
  - Lasts one cycle: frame_done=1, ctrl_done set.
  - Next state is IDLE, or VSYNC if start=1 in that cycle (back-to-back frame; ctrl_done then clears).
- start outside IDLE/DONE is ignored (no queuing).
- abort has priority over start and stall:
  - Next state IDLE; VSYNC/HSYNC drop next cycle; row/col/pix_addr return to reset values.
  - No frame_done pulse; ctrl_done unchanged.
- Unstalled frame length, start to frame_done: START_UP_DELAY + HEIGHT*WIDTH/2 + (HEIGHT-1)*HSYNC_DELAY + 1 cycles.
- Counter arithmetic is unsigned. The delay counter is sized $clog2(max(START_UP_DELAY,HSYNC_DELAY)+1). No counter wraps within a legal frame.
- Elaboration error if WIDTH is odd or any delay is <1.

Decomposition:
- Package image_ctrl_pkg: state enum (IDLE, VSYNC, DATA, HBLANK, DONE); default WIDTH/HEIGHT/delay constants shared with the image source/sink and testbench.
- One sub-module, image_delay_cnt: loadable down-counter with load, load value, and a done flag (count==1). Used for both the VSYNC and HBLANK phases.

Test Plan:
All scenarios use WIDTH=8, HEIGHT=4, START_UP_DELAY=3, HSYNC_DELAY=2.
- Basic frame, BOTTOM_UP=1: start pulse at cycle 0 -> VSYNC high cycles 1-3; 16 HSYNC pulses with rows 3,3,3,3,2,...,0 and col 0,2,4,6 repeating; pix_addr 24,26,28,30,16,...,6; 2 blank cycles between lines; frame_done at cycle 26; ctrl_done=1 thereafter.
- BOTTOM_UP=0: same stimulus -> row 0..3; pix_addr 0,2,...,30 contiguous; line_end on each col=6 beat.
- Stall: stall=1 for 3 cycles at row 3 col 4 -> HSYNC=0 and col held at 4 for 3 cycles; frame_done delayed to cycle 29; no pair skipped or repeated.
- Abort: abort during HBLANK after row 2 -> next cycle busy=0, row=3, col=0, no frame_done; a following start runs a full 16-pair frame.
- Back-to-back: start asserted in the DONE cycle -> ctrl_done clears, VSYNC rises next cycle; start pulses during DATA are ignored.
- Async reset: assert HRESET mid-DATA between clock edges -> all outputs go to reset values immediately, without waiting for an HCLK edge.
